// File: rtl/program_loader_if.sv
// Purpose : groups the byte-stream handshake, program-memory write port and
//           processor/status signals between a host and program_loader.
// Ports   : start, ByteIn, ByteValid (host -> loader); ByteReady, MemWrite,
//           MemAddress, MemWriteData, CpuReset, Busy, Done, Error (loader -> host).
//           master = host/stream side, slave = loader side.
interface program_loader_if;
    logic        start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        MemWrite;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        CpuReset;
    logic        Busy;
    logic        Done;
    logic        Error;

    modport master (
        output start, ByteIn, ByteValid,
        input  ByteReady, MemWrite, MemAddress, MemWriteData,
        input  CpuReset, Busy, Done, Error
    );

    modport slave (
        input  start, ByteIn, ByteValid,
        output ByteReady, MemWrite, MemAddress, MemWriteData,
        output CpuReset, Busy, Done, Error
    );
endinterface

// File: rtl/program_loader.sv
// Purpose : loads a length-prefixed big-endian byte stream into the MIPS
//           instruction memory, one 32-bit write per word, holding the CPU in
//           reset until the load has completed successfully.
// Latency : 4th byte of a word accepted at edge t -> MemWrite asserted for the
//           cycle after t; one word per 5 cycles with a continuous stream.
// Backpr. : ByteReady is a registered state decode; it drops for the single
//           WRITE cycle, so a byte held on ByteIn then is accepted next cycle.
// Ports   : clk, reset (sync, active high), bus (program_loader_if.slave).
// Option  : define PROGRAM_LOADER_CHECKSUM_EN to require a trailing mod-256
//           sum byte over the data bytes before DONE is reached.
module program_loader #(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
    input  logic           clk,
    input  logic           reset,
    program_loader_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_HI  = 3'd1;
    localparam logic [2:0] S_LEN_LO  = 3'd2;
    localparam logic [2:0] S_COLLECT = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK     = 3'd7;
    // Where the load goes once all words (possibly zero) are written.
    localparam logic [2:0] S_FINAL   = S_CHK;
`else
    localparam logic [2:0] S_FINAL   = S_DONE;
`endif

    localparam logic [15:0] DEPTH_W = 16'(MEMORY_DEPTH);

    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        byte_ready_q, rdy_d;
    logic        busy_q, busy_d;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_q;
    logic        cpu_reset_q;
    logic        done_q;
    logic        error_q;
    logic        xfer;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    assign xfer = byte_ready_q & bus.ByteValid;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start) begin
                    state_d = S_LEN_HI;
                    len_d   = 16'd0;
                    idx_d   = 16'd0;
                    cnt_d   = 2'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = bus.ByteIn;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = bus.ByteIn;
                    if (len_d == 16'd0)
                        state_d = S_FINAL;
                    else if (len_d > DEPTH_W)
                        state_d = S_ERROR;
                    else
                        state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (xfer) begin
                    // Big-endian: first byte of a word lands in [31:24].
                    case (cnt_q)
                        2'd0:    word_d[31:24] = bus.ByteIn;
                        2'd1:    word_d[23:16] = bus.ByteIn;
                        2'd2:    word_d[15:8]  = bus.ByteIn;
                        default: word_d[7:0]   = bus.ByteIn;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_d = S_WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + bus.ByteIn;
`endif
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + 16'd1;
                state_d = (idx_d == len_q) ? S_FINAL : S_COLLECT;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer)
                    state_d = (bus.ByteIn == sum_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered decodes of the next state so they
        // line up with state_q on every cycle.
        rdy_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                (state_d == S_COLLECT);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (state_d == S_CHK)
            rdy_d = 1'b1;
`endif
        busy_d = rdy_d || (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= 16'd0;
            idx_q        <= 16'd0;
            cnt_q        <= 2'd0;
            word_q       <= 32'd0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_data_q   <= 32'd0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            byte_ready_q <= rdy_d;
            busy_q       <= busy_d;
            mem_write_q  <= (state_d == S_WRITE);
            // Address uses the index before the WRITE-cycle increment.
            if (state_d == S_WRITE) begin
                mem_addr_q <= BASE_ADDRESS + (32'(idx_q) << 2);
                mem_data_q <= word_d;
            end
            cpu_reset_q  <= (state_d != S_DONE);
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERROR);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign bus.ByteReady    = byte_ready_q;
    assign bus.MemWrite     = mem_write_q;
    assign bus.MemAddress   = mem_addr_q;
    assign bus.MemWriteData = mem_data_q;
    assign bus.CpuReset     = cpu_reset_q;
    assign bus.Busy         = busy_q;
    assign bus.Done         = done_q;
    assign bus.Error        = error_q;
endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
    logic clk;
    logic reset;

    program_loader_if bus ();

    program_loader #(
        .MEMORY_DEPTH (32),
        .BASE_ADDRESS (32'h0040_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];   // {address, data} of each expected write

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next expectation.
    always @(negedge clk) begin
        if (bus.MemWrite === 1'b1) begin
            logic [63:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL memwrite_unexpected got addr=%h data=%h expected none",
                         bus.MemAddress, bus.MemWriteData);
            end else begin
                e = exp_q.pop_front();
                if ({bus.MemAddress, bus.MemWriteData} !== e) begin
                    miscompares++;
                    $display("FAIL memwrite got addr=%h data=%h expected addr=%h data=%h",
                             bus.MemAddress, bus.MemWriteData, e[63:32], e[31:0]);
                end
            end
            vectors++;
            if (bus.ByteReady !== 1'b0) begin
                miscompares++;
                $display("FAIL write_byteready got=%b expected=0", bus.ByteReady);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    // Holds a byte with ByteValid high until it is accepted (bounded).
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus.ByteIn    = b;
        bus.ByteValid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.ByteReady;
            @(posedge clk); #1;
        end
        bus.ByteValid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout got=not_accepted expected=accepted byte=%h", b);
        end
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i]);
    endtask

    task automatic trailer(input logic [7:0] b);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(b);
`else
        if (b === 8'hxx) $display("unused");
`endif
    endtask

    task automatic check_done(input string name);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk({name, "_done"},     32'(bus.Done),     32'd1);
        chk({name, "_error"},    32'(bus.Error),    32'd0);
        chk({name, "_cpureset"}, 32'(bus.CpuReset), 32'd0);
        chk({name, "_busy"},     32'(bus.Busy),     32'd0);
    endtask

    task automatic check_error(input string name);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk({name, "_error"},    32'(bus.Error),    32'd1);
        chk({name, "_done"},     32'(bus.Done),     32'd0);
        chk({name, "_cpureset"}, 32'(bus.CpuReset), 32'd1);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.ByteIn    = 8'h00;
        bus.ByteValid = 1'b0;
        reset         = 1'b1;

        // Reset state (ByteValid high in IDLE must be ignored afterwards).
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_byteready", 32'(bus.ByteReady), 32'd0);
        chk("rst_memwrite",  32'(bus.MemWrite),  32'd0);
        chk("rst_memaddr",   bus.MemAddress,     32'd0);
        chk("rst_memdata",   bus.MemWriteData,   32'd0);
        chk("rst_cpureset",  32'(bus.CpuReset),  32'd1);
        chk("rst_busy",      32'(bus.Busy),      32'd0);
        chk("rst_done",      32'(bus.Done),      32'd0);
        chk("rst_error",     32'(bus.Error),     32'd0);
        @(posedge clk); #1 reset = 1'b0;
        bus.ByteValid = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.ByteValid = 1'b0;
        chk("idle_busy", 32'(bus.Busy), 32'd0);

        // Two-word load, continuous stream; second word's first byte is
        // presented during the first WRITE cycle and must not be lost.
        exp_q.push_back({32'h0040_0000, 32'h2008_0005});
        exp_q.push_back({32'h0040_0004, 32'h0109_5020});
        pulse_start();
        chk("t1_busy", 32'(bus.Busy), 32'd1);
        send_bytes('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                     8'h01, 8'h09, 8'h50, 8'h20});
        @(negedge clk);
        chk("t1_done_early", 32'(bus.Done), 32'd0);
        trailer(8'hA7);
        check_done("t1");

        // Oversize length goes to ERROR without any write.
        pulse_start();
        send_bytes('{8'h00, 8'h21});
        check_error("t2");
        // Recovery with a valid one-word load.
        exp_q.push_back({32'h0040_0000, 32'hAABB_CCDD});
        pulse_start();
        send_bytes('{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
        trailer(8'h0E);
        check_done("t2b");

        // Zero-length load.
        pulse_start();
        send_bytes('{8'h00, 8'h00});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
        check_done("t3");
        pulse_start();
        send_bytes('{8'h00, 8'h00, 8'h01});
        check_error("t3b");
`else
        check_done("t3");
`endif

        // ByteValid toggling every cycle during a one-word load.
        begin
            logic [7:0] bs[6];
            int k;
            int cyc;
            bit acc;
            bs[0] = 8'h00; bs[1] = 8'h01; bs[2] = 8'hDE;
            bs[3] = 8'hAD; bs[4] = 8'hBE; bs[5] = 8'hEF;
            k = 0;
            cyc = 0;
            exp_q.push_back({32'h0040_0000, 32'hDEAD_BEEF});
            pulse_start();
            while (k < 6 && cyc < 200) begin
                bus.ByteIn    = bs[k];
                bus.ByteValid = (cyc % 2 == 0);
                @(negedge clk);
                acc = bus.ByteValid && bus.ByteReady;
                @(posedge clk); #1;
                if (acc) k++;
                cyc++;
            end
            bus.ByteValid = 1'b0;
            chk("t4_bytes_accepted", 32'(k), 32'd6);
            trailer(8'h38);
            check_done("t4");
        end

        // Reset in the middle of a word, then a fresh load from word 0.
        pulse_start();
        send_bytes('{8'h00, 8'h02, 8'h11, 8'h22});
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_busy",      32'(bus.Busy),      32'd0);
        chk("t5_cpureset",  32'(bus.CpuReset),  32'd1);
        chk("t5_byteready", 32'(bus.ByteReady), 32'd0);
        chk("t5_memaddr",   bus.MemAddress,     32'd0);
        exp_q.push_back({32'h0040_0000, 32'h3344_5566});
        pulse_start();
        send_bytes('{8'h00, 8'h01, 8'h33, 8'h44, 8'h55, 8'h66});
        trailer(8'hEE);
        check_done("t5");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Checksum over 01..08 is 0x24.
        exp_q.push_back({32'h0040_0000, 32'h0102_0304});
        exp_q.push_back({32'h0040_0004, 32'h0506_0708});
        pulse_start();
        send_bytes('{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                     8'h05, 8'h06, 8'h07, 8'h08, 8'h24});
        check_done("t6");
        exp_q.push_back({32'h0040_0000, 32'h0102_0304});
        exp_q.push_back({32'h0040_0004, 32'h0506_0708});
        pulse_start();
        send_bytes('{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                     8'h05, 8'h06, 8'h07, 8'h08, 8'h25});
        check_error("t6b");
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
